// File: rtl/echo_tof_meas_if.sv
// ---------------------------------------------------------------------------
// echo_tof_meas_if
//
// Signal bundle between the echo time-of-flight block and its surroundings
// (burst sync / protection from the pulser side, ADC samples and settings in,
// measurement results out).
//
// Signals:
//   burst_syn   burst sync shared with the pulser; rising edge starts a run
//   protect_en  level-sensitive abort request
//   adc_data    10-bit offset-binary ADC sample, midscale 512
//   threshold   9-bit magnitude threshold
//   blank_len   blanking length in cycles, counted from start
//   win_len     listening window length in cycles, counted from start
//   tof         time of flight in cycles, 16'hFFFF after a timeout
//   tof_valid   one-cycle strobe, tof/echo_amp updated
//   timeout     one-cycle strobe, no echo confirmed inside the window
//   echo_amp    peak magnitude of the confirmed echo
//   busy        measurement in progress
//
// Modports:
//   master  the side that supplies sync, samples and settings
//   slave   the measurement block itself
// ---------------------------------------------------------------------------
interface echo_tof_meas_if;
    logic        burst_syn;
    logic        protect_en;
    logic [9:0]  adc_data;
    logic [8:0]  threshold;
    logic [15:0] blank_len;
    logic [15:0] win_len;
    logic [15:0] tof;
    logic        tof_valid;
    logic        timeout;
    logic [8:0]  echo_amp;
    logic        busy;

    modport master (
        output burst_syn, protect_en, adc_data, threshold, blank_len, win_len,
        input  tof, tof_valid, timeout, echo_amp, busy
    );

    modport slave (
        input  burst_syn, protect_en, adc_data, threshold, blank_len, win_len,
        output tof, tof_valid, timeout, echo_amp, busy
    );
endinterface

// File: rtl/echo_tof_meas.sv
// ---------------------------------------------------------------------------
// echo_tof_meas
//
// Receive-side echo timer for the thickness gauge. A rising edge of the
// shared burst sync starts a 16-bit time base. The transducer ring-down is
// ignored for blank_len cycles, after which the digitised echo is searched
// for the first run of HYST_CNT consecutive samples whose magnitude
// |adc_data - 512| reaches the threshold. The start of that run is reported
// as the time of flight. If no run is confirmed before the window of
// win_len cycles closes, a timeout is reported with tof = 16'hFFFF.
//
// Optional feature (macro ECHO_PEAK_EN):
//   When defined, confirmation is followed by PEAK_LEN cycles of peak
//   tracking; tof_valid and echo_amp are issued at the end of that interval.
//   When undefined, tof_valid is issued at confirmation and echo_amp is 0.
//
// Parameters:
//   HYST_CNT   consecutive above-threshold samples that confirm an echo (1..15)
//   PEAK_LEN   peak tracking cycles after confirmation (ECHO_PEAK_EN only, >= 1)
//
// Ports:
//   clk      system clock, adc_data is sampled every cycle
//   RESET_N  asynchronous active-low reset
//   bus      echo_tof_meas_if slave modport (see interface for signal list)
// ---------------------------------------------------------------------------
module echo_tof_meas #(
    parameter int HYST_CNT = 3,
    parameter int PEAK_LEN = 32
) (
    input  logic            clk,
    input  logic            RESET_N,
    echo_tof_meas_if.slave  bus
);

    localparam logic [3:0]  HYST_L   = 4'(HYST_CNT);
    localparam logic [15:0] TCNT_MAX = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_BLANK    = 3'd1,
        ST_SEARCH   = 3'd2,
        ST_CONFIRM  = 3'd3,
        ST_PEAK     = 3'd4,
        ST_WAIT_LOW = 3'd5
    } state_t;

    state_t      state_q;
    logic        burst_d_q;
    logic [15:0] tcnt_q;
    logic [15:0] cand_q;
    logic [3:0]  run_q;
    logic [15:0] tof_q;
    logic        tof_valid_q;
    logic        timeout_q;

    logic        rise;
    logic [9:0]  diff;
    logic [8:0]  mag;
    logic        above;
    logic [15:0] tcnt_d;
    logic        win_end;
    logic        confirm;
    logic [15:0] conf_tof;

    // ------------------------------------------------------------------
    // Sample conditioning and time base helpers
    // ------------------------------------------------------------------
    always_comb begin
        rise = bus.burst_syn & ~burst_d_q;

        // Offset-binary magnitude. Only adc_data = 0 yields 512, which is
        // clamped so the result fits the 9-bit threshold range.
        diff = 10'd0;
        if (bus.adc_data[9]) begin
            mag = bus.adc_data[8:0];
        end else begin
            diff = 10'd512 - bus.adc_data;
            mag  = diff[9] ? 9'd511 : diff[8:0];
        end
        above = (mag >= bus.threshold);

        // The time base parks at its maximum instead of wrapping.
        tcnt_d  = (tcnt_q == TCNT_MAX) ? tcnt_q : tcnt_q + 16'd1;
        win_end = (tcnt_q == bus.win_len - 16'd1);
    end

    // Confirmation decode. With HYST_CNT = 1 the first above sample in
    // SEARCH confirms directly, so its own tcnt is the time of flight.
    always_comb begin
        confirm  = 1'b0;
        conf_tof = cand_q;
        if (above) begin
            if (state_q == ST_SEARCH && HYST_L == 4'd1) begin
                confirm  = 1'b1;
                conf_tof = tcnt_q;
            end else if (state_q == ST_CONFIRM && run_q + 4'd1 == HYST_L) begin
                confirm  = 1'b1;
            end
        end
    end

`ifdef ECHO_PEAK_EN
    localparam logic [15:0] PEAK_LAST = 16'(PEAK_LEN - 1);

    logic [8:0]  run_max_q;
    logic [8:0]  peak_q;
    logic [15:0] pcnt_q;
    logic [8:0]  echo_amp_q;
    logic [8:0]  peak_seed;
    logic [8:0]  peak_d;

    // The peak starts from the largest sample of the confirming run,
    // including the sample that completes it.
    always_comb begin
        if (state_q == ST_SEARCH) begin
            peak_seed = mag;
        end else begin
            peak_seed = (mag > run_max_q) ? mag : run_max_q;
        end
        peak_d = (mag > peak_q) ? mag : peak_q;
    end

    assign bus.echo_amp = echo_amp_q;
`else
    logic unused_peak_len;
    assign unused_peak_len = (PEAK_LEN != 0);
    assign bus.echo_amp    = 9'd0;
`endif

    // ------------------------------------------------------------------
    // Measurement FSM with registered results
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_IDLE;
            burst_d_q   <= 1'b0;
            tcnt_q      <= 16'd0;
            cand_q      <= 16'd0;
            run_q       <= 4'd0;
            tof_q       <= 16'd0;
            tof_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
`ifdef ECHO_PEAK_EN
            run_max_q   <= 9'd0;
            peak_q      <= 9'd0;
            pcnt_q      <= 16'd0;
            echo_amp_q  <= 9'd0;
`endif
        end else begin
            burst_d_q   <= bus.burst_syn;
            tof_valid_q <= 1'b0;
            timeout_q   <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    // An active abort request also suppresses the start.
                    if (rise && !bus.protect_en) begin
                        tcnt_q  <= 16'd0;
                        run_q   <= 4'd0;
                        state_q <= (bus.blank_len == 16'd0) ? ST_SEARCH : ST_BLANK;
                    end
                end

                ST_BLANK, ST_SEARCH, ST_CONFIRM: begin
                    tcnt_q <= tcnt_d;
                    if (bus.protect_en) begin
                        state_q <= ST_WAIT_LOW;
                    end else if (confirm) begin
                        // Confirmation wins over a window end on the same sample.
                        tof_q <= conf_tof;
`ifdef ECHO_PEAK_EN
                        peak_q  <= peak_seed;
                        pcnt_q  <= 16'd0;
                        state_q <= ST_PEAK;
`else
                        tof_valid_q <= 1'b1;
                        state_q     <= ST_WAIT_LOW;
`endif
                    end else if (win_end) begin
                        timeout_q <= 1'b1;
                        tof_q     <= 16'hFFFF;
                        state_q   <= ST_WAIT_LOW;
                    end else if (state_q == ST_BLANK) begin
                        // Leave blanking so that the sample at tcnt = blank_len
                        // is the first one searched.
                        if (tcnt_d == bus.blank_len) begin
                            state_q <= ST_SEARCH;
                        end
                    end else if (state_q == ST_SEARCH) begin
                        if (above) begin
                            cand_q  <= tcnt_q;
                            run_q   <= 4'd1;
                            state_q <= ST_CONFIRM;
`ifdef ECHO_PEAK_EN
                            run_max_q <= mag;
`endif
                        end
                    end else begin
                        if (above) begin
                            run_q <= run_q + 4'd1;
`ifdef ECHO_PEAK_EN
                            run_max_q <= peak_seed;
`endif
                        end else begin
                            state_q <= ST_SEARCH;
                        end
                    end
                end

`ifdef ECHO_PEAK_EN
                ST_PEAK: begin
                    tcnt_q <= tcnt_d;
                    if (bus.protect_en) begin
                        state_q <= ST_WAIT_LOW;
                    end else if (pcnt_q == PEAK_LAST) begin
                        tof_valid_q <= 1'b1;
                        echo_amp_q  <= peak_d;
                        state_q     <= ST_WAIT_LOW;
                    end else begin
                        pcnt_q <= pcnt_q + 16'd1;
                        peak_q <= peak_d;
                    end
                end
`endif

                ST_WAIT_LOW: begin
                    // Re-arm only once the sync has dropped, so a sync that is
                    // still high from this burst cannot restart a measurement.
                    if (!bus.burst_syn) begin
                        state_q <= ST_IDLE;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.tof       = tof_q;
    assign bus.tof_valid = tof_valid_q;
    assign bus.timeout   = timeout_q;
    assign bus.busy      = (state_q == ST_BLANK)   || (state_q == ST_SEARCH) ||
                           (state_q == ST_CONFIRM) || (state_q == ST_PEAK);

endmodule

// File: doc/echo_tof_meas.md
# echo_tof_meas

Receive-side counterpart of the burst pulser in the thickness gauge. On each rising edge of the shared burst sync it starts a time base, ignores the transducer ring-down during a blanking interval, then searches the digitised echo for the first sustained threshold crossing. It reports the time of flight in clk cycles, or a timeout if no echo is confirmed. It sits between the ADC capture register and the thickness computation logic, and shares burst_syn and protect_en with the pulser.

## Interface
- HYST_CNT, 3: number of consecutive above-threshold samples that confirm an echo (1..15).
- PEAK_LEN, 32: cycles of peak tracking after confirmation (used only with ECHO_PEAK_EN).
- clk  in  1  system clock; adc_data is sampled every cycle.
- RESET_N  in  1  asynchronous, active-low reset.
- burst_syn  in  1  burst sync, the same signal that drives the pulser; its rising edge starts a measurement.
- protect_en  in  1  abort request, level-sensitive.
- adc_data  in  10  unsigned offset-binary sample, midscale 512.
- threshold  in  9  magnitude threshold.
- blank_len  in  16  blanking length in cycles, counted from start.
- win_len  in  16  listening window in cycles, counted from start.
- tof  out  16  time of flight in cycles; 16'hFFFF after a timeout.
- tof_valid  out  1  one-cycle strobe: tof and echo_amp are updated.
- timeout  out  1  one-cycle strobe: no echo was confirmed within the window.
- echo_amp  out  9  peak magnitude of the confirmed echo.
- busy  out  1  high in BLANK, SEARCH, CONFIRM and PEAK.

## Operation
- Edge detect: burst_d holds burst_syn delayed by one register. rise = burst_syn & ~burst_d.
- Magnitude: mag = |adc_data − 512|, saturated to 511. above = (mag >= threshold). threshold = 0 makes every sample above.
- tcnt is a 16-bit counter. It is cleared on the start cycle and increments every cycle in BLANK, SEARCH, CONFIRM and PEAK.
- States:
  - IDLE: waits for rise; on rise goes to BLANK with tcnt = 0. If blank_len = 0, goes directly to SEARCH.
  - BLANK: samples are ignored. Moves to SEARCH on the cycle tcnt reaches blank_len.
  - SEARCH: on above, latches cand = tcnt and goes to CONFIRM with run = 1. If HYST_CNT = 1, the echo is confirmed immediately.
  - CONFIRM: each further above sample increments run; when run reaches HYST_CNT the echo is confirmed. A sample that is not above returns to SEARCH with no change to cand outputs.
  - PEAK: present only with the macro (see Configuration).
  - WAIT_LOW: holds until burst_syn = 0, then goes to IDLE.
- On confirmation: tof <= cand.
- Timeout: if tcnt = win_len − 1 in BLANK, SEARCH or CONFIRM without a confirmation, the block pulses timeout, sets tof <= 16'hFFFF, leaves echo_amp unchanged and goes to WAIT_LOW.
  - Confirmation on that same cycle takes priority over timeout.
  - win_len <= blank_len produces a guaranteed timeout.
- protect_en = 1 in any state other than IDLE: the block goes to WAIT_LOW on the next edge. No strobe is issued and tof/echo_amp are unchanged. In IDLE, protect_en blocks the start.
- A rise while busy or in WAIT_LOW is ignored.

## Timing
- Reset: every register and output is 0, and the state is IDLE.
- The start cycle is the clk edge that samples rise. The sample taken one cycle later is tcnt = 0.
- Without the macro, tof_valid asserts on the edge after the HYST_CNT-th consecutive above sample.
- tof, echo_amp and the strobes are registered. tof and echo_amp hold their value until the next update.
- tcnt stops at 16'hFFFF (it does not wrap); the timeout terminates it earlier.

## Configuration
- ECHO_PEAK_EN defined:
  - After confirmation the block enters PEAK, seeding peak with the maximum of the run.
  - For PEAK_LEN cycles it keeps peak = max(peak, mag). It then pulses tof_valid, sets echo_amp = peak and goes to WAIT_LOW.
  - protect_en during PEAK aborts with no strobe.
  - A timeout cannot occur in PEAK.
- ECHO_PEAK_EN undefined:
  - There is no PEAK state.
  - tof_valid pulses at confirmation and the block goes to WAIT_LOW.
  - echo_amp is held at 0.

## Test plan
- blank_len=20, win_len=1000, threshold=100, HYST_CNT=3; adc=512 except adc=700 at tcnt 50..60 -> one tof_valid, tof=50, busy falls.
- Same setup plus a spike adc=700 at tcnt 10..15 (inside blanking) and at 30..31 (too short a run) -> tof=50.
- No echo, win_len=200 -> timeout pulse at tcnt=199, tof=16'hFFFF, no tof_valid.
- protect_en asserted for one cycle at tcnt=40 -> no strobes; a later rise is ignored until burst_syn falls; the next burst measures normally.
- ECHO_PEAK_EN, PEAK_LEN=32, echo ramping to adc=900 at tcnt 55 -> tof=50, echo_amp=388, tof_valid 32 cycles after confirmation.
- RESET_N pulsed low mid-SEARCH -> all outputs 0 immediately, IDLE; the next rise starts cleanly with tcnt=0.
